// File: rtl/mem_stage_waited_pkg.sv
// Shared configuration for the memory stage: bus widths, access-size codes,
// FSM state encodings and the byte-lane mask helper.
package mem_stage_waited_pkg;

    localparam int CFG_WORD_LEN    = 32;
    localparam int CFG_ADDRESS_LEN = 32;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_SIZE_BYTE: return 4'b0001 << lane;
            MEM_SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            MEM_SIZE_WORD: return 4'b1111;
            default:       return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_bank.sv
// DEPTH x 32 data array with per-byte-lane write enables.
// Latency: write commits on the clock edge, read is combinational.
// Backpressure: none; always accepts a write.
module mem_lane_bank #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdat,
    output logic [31:0]   rdat
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];
    logic        addr_ok;

    assign addr_ok = int'(addr) < DEPTH;
    assign rdat    = addr_ok ? mem_q[addr] : 32'h0;

    always_comb begin
        mem_d = mem_q;
        for (int l = 0; l < 4; l++) begin
            if (we[l] && addr_ok) begin
                mem_d[addr][8*l +: 8] = wdat[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/mem_stage_waited.sv
// Pipeline memory stage: byte/half/word loads and stores against a local bank.
// Latency: WAIT_STATES+1 cycles from request to result (result valid in DONE).
// Backpressure: stall held high until the access reaches DONE.
module mem_stage_waited
    import mem_stage_waited_pkg::*;
#(
    parameter int WORD_LEN    = CFG_WORD_LEN,
    parameter int ADDRESS_LEN = CFG_ADDRESS_LEN,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRESS_LEN-1:0] pc_in,
    output logic [ADDRESS_LEN-1:0] pc,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [1:0]             MEM_SIZE,
    input  logic                   MEM_SIGNED,
    input  logic [ADDRESS_LEN-1:0] ALU_Res,
    input  logic [WORD_LEN-1:0]    Val_Rm,
    output logic [WORD_LEN-1:0]    memory_out,
    output logic                   stall,
    output logic                   mem_err
);

    localparam int                     AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_LEN-1:0] BASE      = ADDRESS_LEN'(BASE_ADDR);
    localparam logic [ADDRESS_LEN-1:0] LIMIT     = ADDRESS_LEN'(DEPTH * 4);
    localparam logic [3:0]             WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [ADDRESS_LEN-1:0]   pc_q, pc_d;
    logic [WORD_LEN-1:0]      memory_out_q, memory_out_d;
    logic                     mem_err_q, mem_err_d;

    logic                     req;
    logic                     fire;
    logic                     acc_err;
    logic [ADDRESS_LEN-1:0]   off;
    logic [1:0]               lane;
    logic [AW-1:0]            widx;
    logic [3:0]               we;
    logic [WORD_LEN-1:0]      wdat;
    logic [WORD_LEN-1:0]      rdat;
    logic [WORD_LEN-1:0]      shifted;
    logic [WORD_LEN-1:0]      ld_val;

    assign req   = MEM_R_EN | MEM_W_EN;
    assign off   = ALU_Res - BASE;
    assign lane  = off[1:0];
    assign widx  = off[AW+1:2];
    assign stall = req && (state_q != ST_DONE);

    always_comb begin
        acc_err = 1'b0;
        if (ALU_Res < BASE) acc_err = 1'b1;
        if (off >= LIMIT)   acc_err = 1'b1;
        case (MEM_SIZE)
            MEM_SIZE_BYTE: ;
            MEM_SIZE_HALF: if (off[0])        acc_err = 1'b1;
            MEM_SIZE_WORD: if (lane != 2'b00) acc_err = 1'b1;
            default:       acc_err = 1'b1;
        endcase
        if (MEM_R_EN && MEM_W_EN) acc_err = 1'b1;
    end

    // Store data is replicated across lanes; the lane mask picks the bytes that land.
    always_comb begin
        case (MEM_SIZE)
            MEM_SIZE_BYTE: wdat = {4{Val_Rm[7:0]}};
            MEM_SIZE_HALF: wdat = {2{Val_Rm[15:0]}};
            default:       wdat = Val_Rm;
        endcase
        we = (fire && MEM_W_EN && !acc_err) ? lane_mask(MEM_SIZE, lane) : 4'b0000;
    end

    always_comb begin
        shifted = rdat >> {lane, 3'b000};
        case (MEM_SIZE)
            MEM_SIZE_BYTE: ld_val = {{(WORD_LEN-8){MEM_SIGNED & shifted[7]}}, shifted[7:0]};
            MEM_SIZE_HALF: ld_val = {{(WORD_LEN-16){MEM_SIGNED & shifted[15]}}, shifted[15:0]};
            default:       ld_val = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_DONE;
                        fire    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_DONE;
                    fire    = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Results only move on the edge that enters DONE; otherwise they hold.
    always_comb begin
        pc_d         = stall ? pc_q : pc_in;
        memory_out_d = memory_out_q;
        mem_err_d    = mem_err_q;
        if (fire) begin
            mem_err_d = acc_err;
            if (MEM_R_EN) begin
                memory_out_d = acc_err ? '0 : ld_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            pc_q         <= '0;
            memory_out_q <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            memory_out_q <= memory_out_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign pc         = pc_q;
    assign memory_out = memory_out_q;
    assign mem_err    = mem_err_q;

    mem_lane_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (widx),
        .wdat (wdat),
        .rdat (rdat)
    );

endmodule

// File: tb/tb_mem_stage_waited.sv
// Directed bench for mem_stage_waited: a WAIT_STATES=2 instance for the main
// sequence and a WAIT_STATES=0 instance for the zero-wait timing.
module tb_mem_stage_waited;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] pc_in0, pc0, alu0, val0, out0;
    logic        r0, w0, sg0, stall0, err0;
    logic [1:0]  sz0;
    logic [31:0] pc_in1, pc1, alu1, val1, out1;
    logic        r1, w1, sg1, stall1, err1;
    logic [1:0]  sz1;

    int checks = 0;
    int errors = 0;

    mem_stage_waited #(.WAIT_STATES(2)) u_dut (
        .clk(clk), .rst(rst), .pc_in(pc_in0), .pc(pc0),
        .MEM_R_EN(r0), .MEM_W_EN(w0), .MEM_SIZE(sz0), .MEM_SIGNED(sg0),
        .ALU_Res(alu0), .Val_Rm(val0), .memory_out(out0), .stall(stall0), .mem_err(err0)
    );

    mem_stage_waited #(.WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst(rst), .pc_in(pc_in1), .pc(pc1),
        .MEM_R_EN(r1), .MEM_W_EN(w1), .MEM_SIZE(sz1), .MEM_SIGNED(sg1),
        .ALU_Res(alu1), .Val_Rm(val1), .memory_out(out1), .stall(stall1), .mem_err(err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one access at posedge+1 from IDLE, count stall cycles, check results
    // in the DONE cycle, then release the request after the DONE edge.
    task automatic access(input bit sel, input string tag, input logic r, input logic w,
                          input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] d, input int exp_st,
                          input logic [31:0] exp_out, input logic exp_err);
        int nst = 0;
        if (!sel) begin
            r0 = r; w0 = w; sz0 = sz; sg0 = sg; alu0 = a; val0 = d;
        end else begin
            r1 = r; w1 = w; sz1 = sz; sg1 = sg; alu1 = a; val1 = d;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!(sel ? stall1 : stall0)) break;
            nst++;
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_stall_cycles"}, nst, exp_st);
        check_eq({tag, "_out"}, sel ? out1 : out0, exp_out);
        check_eq({tag, "_err"}, {31'b0, sel ? err1 : err0}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        if (!sel) begin
            r0 = 1'b0; w0 = 1'b0;
        end else begin
            r1 = 1'b0; w1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pc_in0 = 32'd0; alu0 = 32'd0; val0 = 32'd0; r0 = 1'b0; w0 = 1'b0; sz0 = SZ_W; sg0 = 1'b0;
        pc_in1 = 32'd0; alu1 = 32'd0; val1 = 32'd0; r1 = 1'b0; w1 = 1'b0; sz1 = SZ_W; sg1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_pc", pc0, 32'h0);
        check_eq("rst_out", out0, 32'h0);
        check_eq("rst_err", {31'b0, err0}, 32'h0);
        check_eq("rst_stall", {31'b0, stall0}, 32'h0);
        @(posedge clk);
        #1;

        access(0, "st_w",      0, 1, SZ_W, 0, 32'd1024, 32'hDEADBEEF, 3, 32'h00000000, 0);
        access(0, "ld_w",      1, 0, SZ_W, 0, 32'd1024, 32'h0,        3, 32'hDEADBEEF, 0);
        access(0, "st_b",      0, 1, SZ_B, 0, 32'd1026, 32'h00000011, 3, 32'hDEADBEEF, 0);
        access(0, "ld_w2",     1, 0, SZ_W, 0, 32'd1024, 32'h0,        3, 32'hDE11BEEF, 0);
        access(0, "ld_bs",     1, 0, SZ_B, 1, 32'd1027, 32'h0,        3, 32'hFFFFFFDE, 0);
        access(0, "ld_bu",     1, 0, SZ_B, 0, 32'd1027, 32'h0,        3, 32'h000000DE, 0);
        access(0, "ld_hs0",    1, 0, SZ_H, 1, 32'd1024, 32'h0,        3, 32'hFFFFBEEF, 0);
        access(0, "ld_hs2",    1, 0, SZ_H, 1, 32'd1026, 32'h0,        3, 32'hFFFFDE11, 0);
        access(0, "ld_hu2",    1, 0, SZ_H, 0, 32'd1026, 32'h0,        3, 32'h0000DE11, 0);
        access(0, "ld_ws",     1, 0, SZ_W, 1, 32'd1024, 32'h0,        3, 32'hDE11BEEF, 0);
        access(0, "st_h_hi",   0, 1, SZ_H, 0, 32'd1030, 32'h9999A1B2, 3, 32'hDE11BEEF, 0);
        access(0, "st_b_lo",   0, 1, SZ_B, 0, 32'd1028, 32'h88888877, 3, 32'hDE11BEEF, 0);
        access(0, "ld_w1028",  1, 0, SZ_W, 0, 32'd1028, 32'h0,        3, 32'hA1B20077, 0);
        access(0, "err_ld_w",  1, 0, SZ_W, 0, 32'd1025, 32'h0,        3, 32'h00000000, 1);
        access(0, "err_below", 0, 1, SZ_W, 0, 32'd1020, 32'h12345678, 3, 32'h00000000, 1);
        access(0, "err_above", 0, 1, SZ_W, 0, 32'd1280, 32'h12345678, 3, 32'h00000000, 1);
        access(0, "chk_w63",   1, 0, SZ_W, 0, 32'd1276, 32'h0,        3, 32'h00000000, 0);
        access(0, "chk_w0",    1, 0, SZ_W, 0, 32'd1024, 32'h0,        3, 32'hDE11BEEF, 0);
        access(0, "err_rw",    1, 1, SZ_W, 0, 32'd1024, 32'h55555555, 3, 32'h00000000, 1);
        access(0, "err_ld_h",  1, 0, SZ_H, 1, 32'd1025, 32'h0,        3, 32'h00000000, 1);
        access(0, "err_sz",    1, 0, SZ_X, 0, 32'd1024, 32'h0,        3, 32'h00000000, 1);

        // Pipeline hold: pc freezes while stalled, picks up pc_in in DONE.
        pc_in0 = 32'd50;
        @(posedge clk);
        #1;
        check_eq("pc_transparent", pc0, 32'd50);
        r0 = 1'b1; sz0 = SZ_W; sg0 = 1'b0; alu0 = 32'd1024; pc_in0 = 32'd100;
        @(negedge clk);
        check_eq("hold_stall_c0", {31'b0, stall0}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("hold_pc_c1", pc0, 32'd50);
        pc_in0 = 32'd101;
        @(posedge clk);
        #1;
        check_eq("hold_pc_c2", pc0, 32'd50);
        pc_in0 = 32'd102;
        @(posedge clk);
        #1;
        check_eq("hold_pc_done", pc0, 32'd50);
        pc_in0 = 32'd103;
        @(negedge clk);
        check_eq("hold_stall_done", {31'b0, stall0}, 32'd0);
        check_eq("hold_out", out0, 32'hDE11BEEF);
        @(posedge clk);
        #1;
        check_eq("hold_pc_after", pc0, 32'd103);
        r0 = 1'b0;
        @(posedge clk);
        #1;

        access(1, "ws0_st", 0, 1, SZ_W, 0, 32'd1024, 32'hA5A55A5A, 1, 32'h00000000, 0);
        access(1, "ws0_ld", 1, 0, SZ_W, 0, 32'd1024, 32'h0,        1, 32'hA5A55A5A, 0);

        // Reset during WAIT drops the pending store.
        w0 = 1'b1; sz0 = SZ_W; alu0 = 32'd1028; val0 = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rst = 1'b1;
        w0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_stall", {31'b0, stall0}, 32'd0);
        check_eq("midrst_pc", pc0, 32'd0);
        check_eq("midrst_out", out0, 32'd0);
        check_eq("midrst_err", {31'b0, err0}, 32'd0);
        @(posedge clk);
        #1;
        access(0, "midrst_ld", 1, 0, SZ_W, 0, 32'd1028, 32'h0, 3, 32'h00000000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
